alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue-side controller that drives the ALU: decodes MIPS ALUOp/funct to the 4-bit ALU op,
//  selects and extends operands, presents them to the ALU, then captures dout/zero.
//  Sits in the EX stage between decode (valid/ready in) and writeback (valid/ready out).
// PARAMETERS
//  WIDTH    32  datapath width; imm16 is extended to WIDTH
//  ALU_LAT  1   cycles from alu_* drive to valid alu_dout/alu_zero (>=1)
// PORTS
//  clk        in   1      rising-edge clock, sole clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request accepted when in_valid && in_ready
//  alu_class  in   2      00 ADD (lw/sw), 01 SUB (beq), 10 R-type (use funct), 11 reserved
//  funct      in   6      R-type function field
//  rs_data    in   WIDTH  operand A
//  rt_data    in   WIDTH  operand B when use_imm=0
//  imm16      in   16     immediate
//  use_imm    in   1      1: B = extended imm16
//  zext_imm   in   1      1: zero-extend imm16, 0: sign-extend
//  alu_a      out  WIDTH  to ALU din_A (registered)
//  alu_b      out  WIDTH  to ALU din_B (registered)
//  alu_op     out  4      to ALU op (registered)
//  alu_dout   in   WIDTH  from ALU
//  alu_zero   in   1      from ALU
//  res_valid  out  1      result valid
//  res_ready  in   1      result consumed when res_valid && res_ready
//  result     out  WIDTH  captured ALU result
//  zero       out  1      captured ALU zero flag
//  illegal    out  1      decode failed for this request
//  ovf        out  1      signed overflow (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; alu_a/alu_b/result=0, alu_op=4'b0000; res_valid/zero/illegal/ovf=0.
//    in_ready=0 while rst=1. rst mid-operation abandons the request; nothing is emitted.
//  Decode: class 00->0010, 01->0110. Class 10 by funct:
//    100000/100001->0010, 100010/100011->0110, 100100->0000, 100101->0001,
//    100111->1100, 100110->1101. Any other funct, or class 11, is illegal.
//  FSM IDLE/WAIT/DONE. in_ready = (state==IDLE) || (state==DONE && res_ready).
//  Accept (legal) at edge E: load alu_a=rs_data, alu_b=rt_data or ext(imm16), alu_op; go WAIT,
//    cnt=ALU_LAT. WAIT: cnt decrements each edge. At edge E+ALU_LAT: capture alu_dout->result,
//    alu_zero->zero, compute ovf; illegal=0; go DONE. res_valid=1 in DONE.
//  Accept (illegal): alu_* regs unchanged; go DONE at next edge with result=0, zero=0,
//    illegal=1, ovf=0.
//  DONE: outputs held stable until res_ready. On res_ready: pop. If in_valid is also high,
//    accept the next request on the same edge (goes WAIT or DONE). Otherwise go IDLE.
//    res_valid drops only on a pop that accepts no request or leads to WAIT.
//  Operand/output regs change only at accept/capture; inputs ignored outside accept.
//  Arithmetic is modulo 2^WIDTH and is performed by the ALU only.
// CONFIGURATION
//  ALU_OVF_TRAP_EN defined: ovf captured with result. It is the signed overflow of A+B
//    (funct 100000) or A-B (funct 100010), computed from alu_a, alu_b, alu_dout sign bits.
//    Set for class-10 add/sub only; 0 for addu/subu/classes 00,01 and all other ops.
//    The result is still delivered.
//  Undefined: ovf tied 0; the overflow logic is not built.
// TESTING
//  1 class10 funct100100, A=0xBEEF B=0xCAFE, ALU_LAT=1 -> result 0x8AEE, res_valid 2 cycles
//    after accept; funct100101 -> 0xFEFF; funct100110 -> 0x7411.
//  2 class10 funct100000 -> 0x000189ED. funct100010 -> 0xFFFFF3F1, zero=0.
//    funct100111 -> 0xFFFF0100.
//  3 class00 use_imm=1 zext=0 imm=0xFFFF rs=5 -> 4. zext=1 -> 0x00010004.
//    class01 rs=rt=0x1234 -> result 0, zero=1.
//  4 class10 funct 0x3F -> illegal=1, result=0, res_valid 1 cycle after accept.
//    class11 -> illegal=1.
//  5 res_ready low 5 cycles in DONE -> result/zero stable, in_ready=0.
//    Raise res_ready with in_valid -> pop+accept same edge. rst in WAIT -> res_valid never rises.
//  6 funct100000 A=0x7FFFFFFF B=1 -> result 0x80000000, ovf=1 with ALU_OVF_TRAP_EN, 0 without.
//    funct100001 same operands -> ovf=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: EX-stage issue controller in front of a MIPS-style ALU.
// Decodes ALUOp class/funct into the 4-bit ALU op. Selects operand B as
// rt_data or imm16, with imm16 zero- or sign-extended. Registers the operands
// toward the ALU, waits ALU_LAT cycles, then captures dout/zero for writeback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        request handshake from decode
//   alu_class, funct         ALUOp class and R-type function field
//   rs_data, rt_data, imm16  operand sources; use_imm/zext_imm pick B
//   alu_a, alu_b, alu_op     registered drive to the ALU
//   alu_dout, alu_zero       ALU response
//   res_valid/res_ready      result handshake to writeback
//   result, zero, illegal    captured result, zero flag, decode failure
//   ovf                      signed overflow of add/sub
// Optional feature: define ALU_OVF_TRAP_EN to build overflow detection.
// When it is undefined, ovf is tied to 0.
module alu_issue_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_class,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [15:0]      imm16,
  input  logic             use_imm,
  input  logic             zext_imm,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_dout,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             ovf
);

  localparam int unsigned CNT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);
  localparam int unsigned IMM_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept_c, capture_c, legal_c;
  logic [3:0]       op_c;
  logic [WIDTH-1:0] b_sel_c;

  // Decode of ALUOp class / funct.
  always_comb begin
    legal_c = 1'b1;
    op_c    = 4'b0000;
    case (alu_class)
      2'b00: op_c = 4'b0010;
      2'b01: op_c = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: op_c = 4'b0010;
          6'b100010, 6'b100011: op_c = 4'b0110;
          6'b100100:            op_c = 4'b0000;
          6'b100101:            op_c = 4'b0001;
          6'b100111:            op_c = 4'b1100;
          6'b100110:            op_c = 4'b1101;
          default:              legal_c = 1'b0;
        endcase
      end
      default: legal_c = 1'b0;
    endcase
  end

  // Operand B selection with immediate extension.
  always_comb begin
    b_sel_c = rt_data;
    if (use_imm) begin
      if (zext_imm) b_sel_c = {{(WIDTH-IMM_W){1'b0}}, imm16};
      else          b_sel_c = {{(WIDTH-IMM_W){imm16[IMM_W-1]}}, imm16};
    end
  end

  // A pop in DONE frees the slot on the same edge.
  assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_DONE) && res_ready));
  assign accept_c  = in_valid && in_ready;
  assign capture_c = (state == S_WAIT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept_c) state_nxt = legal_c ? S_WAIT : S_DONE;
      S_WAIT: if (capture_c) state_nxt = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          if (accept_c) state_nxt = legal_c ? S_WAIT : S_DONE;
          else          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // res_valid tracks the registered DONE state.
  always_ff @(posedge clk) begin
    if (rst) res_valid <= 1'b0;
    else     res_valid <= (state_nxt == S_DONE);
  end

  // Operand, latency counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= 4'b0000;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (accept_c && legal_c) begin
        alu_a  <= rs_data;
        alu_b  <= b_sel_c;
        alu_op <= op_c;
        cnt    <= CNT_W'(ALU_LAT);
      end else if (state == S_WAIT && !capture_c) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture_c) begin
        result  <= alu_dout;
        zero    <= alu_zero;
        illegal <= 1'b0;
      end else if (accept_c && !legal_c) begin
        result  <= '0;
        zero    <= 1'b0;
        illegal <= 1'b1;
      end
    end
  end

`ifdef ALU_OVF_TRAP_EN
  // Only trapping add/sub (not addu/subu or class 00/01) can flag overflow.
  typedef enum logic [1:0] {OK_NONE, OK_ADD, OK_SUB} ovf_kind_t;

  ovf_kind_t ovf_kind, ovf_kind_c;
  logic      ovf_r, ovf_c;
  logic      sa, sb, sd;

  always_comb begin
    ovf_kind_c = OK_NONE;
    if (alu_class == 2'b10) begin
      if (funct == 6'b100000)      ovf_kind_c = OK_ADD;
      else if (funct == 6'b100010) ovf_kind_c = OK_SUB;
    end
  end

  assign sa = alu_a[WIDTH-1];
  assign sb = alu_b[WIDTH-1];
  assign sd = alu_dout[WIDTH-1];

  always_comb begin
    ovf_c = 1'b0;
    case (ovf_kind)
      OK_ADD:  ovf_c = (sa == sb) && (sd != sa);
      OK_SUB:  ovf_c = (sa != sb) && (sd != sa);
      default: ovf_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_kind <= OK_NONE;
      ovf_r    <= 1'b0;
    end else begin
      if (accept_c && legal_c) ovf_kind <= ovf_kind_c;
      if (capture_c)                    ovf_r <= ovf_c;
      else if (accept_c && !legal_c)    ovf_r <= 1'b0;
    end
  end

  assign ovf = ovf_r;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural single-cycle ALU and
// a queue of expected results.
module tb_alu_issue_ctrl;
  localparam int unsigned W = 32;
`ifdef ALU_OVF_TRAP_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clk, rst, in_valid, in_ready, use_imm, zext_imm;
  logic [1:0]   alu_class;
  logic [5:0]   funct;
  logic [W-1:0] rs_data, rt_data, alu_a, alu_b, alu_dout, result;
  logic [15:0]  imm16;
  logic [3:0]   alu_op;
  logic         alu_zero, res_valid, res_ready, zero, illegal, ovf;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
    logic         ov;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_issue_ctrl #(.WIDTH(W), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_class(alu_class), .funct(funct), .rs_data(rs_data), .rt_data(rt_data),
    .imm16(imm16), .use_imm(use_imm), .zext_imm(zext_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_dout(alu_dout), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .result(result),
    .zero(zero), .illegal(illegal), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU, combinational on the registered operands.
  always_comb begin
    alu_dout = '0;
    case (alu_op)
      4'b0010: alu_dout = alu_a + alu_b;
      4'b0110: alu_dout = alu_a - alu_b;
      4'b0000: alu_dout = alu_a & alu_b;
      4'b0001: alu_dout = alu_a | alu_b;
      4'b1100: alu_dout = ~(alu_a | alu_b);
      4'b1101: alu_dout = alu_a ^ alu_b;
      default: alu_dout = '0;
    endcase
    alu_zero = (alu_dout == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] cls, input logic [5:0] fn,
                           input logic [W-1:0] rs, input logic [W-1:0] rt,
                           input logic [15:0] imm, input logic ui, input logic zx);
    int n;
    @(negedge clk);
    alu_class = cls; funct = fn; rs_data = rs; rt_data = rt;
    imm16 = imm; use_imm = ui; zext_imm = zx; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_at_issue", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait for res_valid, compare against the oldest expectation, then pop.
  task automatic collect();
    exp_t e;
    int   lat;
    e = sb.pop_front();
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 20);
    chk("latency", W'(lat), W'(e.lat));
    chk("result", result, e.res);
    chk("zero", W'(zero), W'(e.z));
    chk("illegal", W'(illegal), W'(e.ill));
    chk("ovf", W'(ovf), W'(e.ov));
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("res_valid_after_pop", W'(res_valid), W'(0));
  endtask

  task automatic req(input logic [1:0] cls, input logic [5:0] fn,
                     input logic [W-1:0] rs, input logic [W-1:0] rt,
                     input logic [15:0] imm, input logic ui, input logic zx,
                     input logic [W-1:0] eres, input logic ez, input logic eill,
                     input logic eov, input int elat);
    sb.push_back('{res: eres, z: ez, ill: eill, ov: eov, lat: elat});
    drive_req(cls, fn, rs, rt, imm, ui, zx);
    collect();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    alu_class = 2'b00; funct = '0; rs_data = '0; rt_data = '0;
    imm16 = '0; use_imm = 1'b0; zext_imm = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_res_valid", W'(res_valid), W'(0));
    chk("rst_alu_a", alu_a, W'(0));
    chk("rst_alu_op", W'(alu_op), W'(0));
    chk("rst_result", result, W'(0));
    chk("rst_illegal", W'(illegal), W'(0));
    chk("rst_ovf", W'(ovf), W'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", W'(in_ready), W'(1));

    // Logic ops
    req(2'b10, 6'b100100, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'h8AEE, 1'b0, 1'b0, 1'b0, 2);
    req(2'b10, 6'b100101, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'hFEFF, 1'b0, 1'b0, 1'b0, 2);
    req(2'b10, 6'b100110, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'h7411, 1'b0, 1'b0, 1'b0, 2);
    // Arithmetic and nor
    req(2'b10, 6'b100000, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'h000189ED, 1'b0, 1'b0, 1'b0, 2);
    req(2'b10, 6'b100010, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'hFFFFF3F1, 1'b0, 1'b0, 1'b0, 2);
    req(2'b10, 6'b100111, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'hFFFF0100, 1'b0, 1'b0, 1'b0, 2);
    req(2'b10, 6'b100011, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0, 32'hFFFFF3F1, 1'b0, 1'b0, 1'b0, 2);

    // Immediates and branch compare
    req(2'b00, 6'b000000, 32'd5, 32'hDEAD, 16'hFFFF, 1'b1, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 2);
    chk("sext_alu_b", alu_b, 32'hFFFFFFFF);
    chk("sext_alu_op", W'(alu_op), W'(4'b0010));
    req(2'b00, 6'b000000, 32'd5, 32'hDEAD, 16'hFFFF, 1'b1, 1'b1, 32'h00010004, 1'b0, 1'b0, 1'b0, 2);
    chk("zext_alu_b", alu_b, 32'h0000FFFF);
    req(2'b01, 6'b000000, 32'h1234, 32'h1234, 16'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2);

    // Illegal decodes leave operand registers untouched
    req(2'b10, 6'b111111, 32'h5555, 32'h6666, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    req(2'b11, 6'b100000, 32'h7777, 32'h8888, 16'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1);
    chk("illegal_alu_a_held", alu_a, 32'h1234);
    chk("illegal_alu_op_held", W'(alu_op), W'(4'b0110));

    // Backpressure: hold in DONE, then pop and accept on one edge
    sb.push_back('{res: 32'h8AEE, z: 1'b0, ill: 1'b0, ov: 1'b0, lat: 2});
    drive_req(2'b10, 6'b100100, 32'hBEEF, 32'hCAFE, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res_valid", W'(res_valid), W'(1));
      chk("hold_result", result, 32'h8AEE);
      chk("hold_in_ready", W'(in_ready), W'(0));
      @(negedge clk);
    end
    e = sb.pop_front();
    chk("hold_result_pop", result, e.res);
    alu_class = 2'b10; funct = 6'b100101; rs_data = 32'hBEEF; rt_data = 32'hCAFE;
    use_imm = 1'b0; in_valid = 1'b1; res_ready = 1'b1;
    #1 chk("pop_accept_in_ready", W'(in_ready), W'(1));
    sb.push_back('{res: 32'hFEFF, z: 1'b0, ill: 1'b0, ov: 1'b0, lat: 2});
    @(posedge clk);
    #1 begin in_valid = 1'b0; res_ready = 1'b0; end
    collect();

    // Reset while waiting on the ALU abandons the request
    drive_req(2'b10, 6'b100000, 32'h1, 32'h2, 16'h0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_mid_res_valid", W'(res_valid), W'(0));
    end
    chk("rst_mid_result", result, W'(0));

    // Signed overflow
    req(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 16'h0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, OVF_EN, 2);
    req(2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1, 16'h0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 2);
    req(2'b10, 6'b100010, 32'h80000000, 32'h1, 16'h0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, OVF_EN, 2);
    req(2'b10, 6'b100011, 32'h80000000, 32'h1, 16'h0, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 2);
    req(2'b00, 6'b000000, 32'h7FFFFFFF, 32'h1, 16'h0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
